mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles awaiting sram_ok before abort (8-bit count).
REQ-002 Timing: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  pipeline flush; cancels delivery of an in-flight fetch.
REQ-006 inst_req  in  1  fetch request, held until inst_ok.
REQ-007 inst_addr  in  32  fetch address.
REQ-008 inst_ok  out  1  one-cycle fetch-complete pulse.
REQ-009 inst_rdata  out  32  fetch data, valid with inst_ok.
REQ-010 data_req  in  1  load/store request, held until data_ok.
REQ-011 data_wen  in  4  byte write enables; 0 = load.
REQ-012 data_addr  in  32  load/store address.
REQ-013 data_wdata  in  32  store data.
REQ-014 data_ok  out  1  one-cycle load/store-complete pulse.
REQ-015 data_rdata  out  32  load data, valid with data_ok.
REQ-016 sram_en, sram_wen[4], sram_addr[32], sram_wdata[32]  out  shared SRAM port.
REQ-017 sram_rdata  in  32; sram_ok  in  1  SRAM read data and completion strobe.
REQ-018 stallreq_inst, stallreq_data  out  1 each  stall requests to the stall controller.
REQ-019 timeout_err  out  1  sticky flag, set on timeout.

Function
REQ-020 FSM states IDLE, DATA, INST, RESP; RESP is the single turnaround cycle.
REQ-021 IDLE: data_req=1 -> DATA; else inst_req=1 and flush=0 -> INST; else stay IDLE.
REQ-022 Both requests in IDLE -> data wins; inst waits for the next IDLE.
REQ-023 IDLE->DATA/INST latches addr/wen/wdata (inst: wen=0, wdata=0) into port registers.
REQ-024 DATA/INST: sram_en=1 and port outputs stable from latched values every cycle until sram_ok.
REQ-025 Outside DATA/INST: sram_en=0; sram_wen=0.
REQ-026 sram_ok=1 in DATA -> RESP; next cycle data_ok=1, data_rdata=sram_rdata registered (0 for stores).
REQ-027 sram_ok=1 in INST -> RESP; next cycle inst_ok=1, inst_rdata=sram_rdata registered, unless cancelled.
REQ-028 flush=1 in INST or same cycle as its sram_ok -> cancel flag set; the transaction still completes on SRAM, inst_ok suppressed.
REQ-029 Cancel flag cleared on entry to IDLE; flush has no effect on DATA.
REQ-030 RESP -> IDLE unconditionally; minimum request-to-ok latency 3 cycles (sram_ok in first DATA/INST cycle).
REQ-031 Wait counter resets to 0 on entering DATA/INST, increments each cycle without sram_ok.
REQ-032 Counter = TIMEOUT without sram_ok -> timeout_err=1, return to RESP, ok pulse with rdata=0.
REQ-033 timeout_err cleared only by reset.
REQ-034 stallreq_data = data_req & ~data_ok; stallreq_inst = inst_req & ~inst_ok & ~flush (combinational).
REQ-035 inst_ok and data_ok never high in the same cycle; at most one SRAM transaction outstanding.

Reset
REQ-036 rst=0 forces at once: state IDLE, all outputs 0, counter 0, cancel 0, timeout_err 0.
REQ-037 Reset mid-transaction drops it with no ok pulse; after release, a request still held is re-arbitrated from IDLE.

Verification
REQ-038 Load: data_req, addr 0x100, wen 0, sram_ok 1st cycle, rdata 0xDEADBEEF -> data_ok cycle 3, data_rdata 0xDEADBEEF.
REQ-039 Simultaneous inst_req 0xBFC00000 and data_req store wen 0xF -> data served first, then inst; sram_en never drops the data write early.
REQ-040 Fetch with sram_ok after 5 wait cycles, flush pulsed in wait cycle 2 -> no inst_ok, FSM back in IDLE, stallreq_inst 0 during flush.
REQ-041 Fetch, sram_ok never asserted, TIMEOUT=4 -> inst_ok with rdata 0 after 4 wait cycles, timeout_err=1 and held.
REQ-042 rst=0 asserted while in DATA -> outputs 0 immediately; held data_req after release -> fresh DATA transaction and one data_ok.
REQ-043 Back-to-back loads, 2 requests -> exactly one RESP cycle between transactions; 2 data_ok pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM port between an instruction-fetch master and a
// load/store master. Data requests win arbitration; one transaction at a time;
// every transaction ends with a single turnaround cycle that carries the ok pulse.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   flush                     cancels delivery of an in-flight fetch
//   inst_req/inst_addr        fetch request (held until inst_ok)
//   inst_ok/inst_rdata        fetch-complete pulse and data
//   data_req/wen/addr/wdata   load/store request (held until data_ok), wen=0 is a load
//   data_ok/data_rdata        load/store-complete pulse and load data
//   sram_*                    shared SRAM port (en, wen, addr, wdata, rdata, ok)
//   stallreq_inst/data        stall requests to the stall controller
//   timeout_err               sticky flag set when sram_ok never arrives in time
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ok,
  output logic        stallreq_inst,
  output logic        stallreq_data,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StData, StInst, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cancel_q, cancel_d;
  logic        terr_q, terr_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic busy;
  logic timeout_hit;
  logic done;

  assign busy        = (state_q == StData) || (state_q == StInst);
  assign timeout_hit = busy && !sram_ok && (cnt_q == TimeoutCnt);
  assign done        = busy && (sram_ok || timeout_hit);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (data_req) begin
          state_d = StData;
        end else if (inst_req && !flush) begin
          state_d = StInst;
        end
      end
      StData, StInst: begin
        if (done) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: port latches, wait counter, cancel and response registers
  always_comb begin
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cancel_d     = cancel_q;
    terr_d       = terr_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = 32'd0;
    data_rdata_d = 32'd0;

    if (state_q == StIdle) begin
      cnt_d    = 8'd0;
      cancel_d = 1'b0;
      if (data_req) begin
        addr_d  = data_addr;
        wen_d   = data_wen;
        wdata_d = data_wdata;
      end else if (inst_req && !flush) begin
        addr_d  = inst_addr;
        wen_d   = 4'd0;
        wdata_d = 32'd0;
      end
    end

    if (state_q == StResp) begin
      cancel_d = 1'b0;
    end

    if (busy) begin
      if ((state_q == StInst) && flush) cancel_d = 1'b1;
      if (done) begin
        if (timeout_hit) terr_d = 1'b1;
        if (state_q == StData) begin
          data_ok_d = 1'b1;
          if (!timeout_hit && (wen_q == 4'd0)) data_rdata_d = sram_rdata;
        end else begin
          // A flush in the completing cycle suppresses delivery just like an earlier one
          inst_ok_d = !(cancel_q || flush);
          if (inst_ok_d && !timeout_hit) inst_rdata_d = sram_rdata;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= 32'd0;
      wen_q        <= 4'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= 8'd0;
      cancel_q     <= 1'b0;
      terr_q       <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cancel_q     <= cancel_d;
      terr_q       <= terr_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // Outputs; stall requests are gated by reset so every output reads 0 while held in reset
  always_comb begin
    sram_en       = busy;
    sram_wen      = busy ? wen_q : 4'd0;
    sram_addr     = addr_q;
    sram_wdata    = wdata_q;
    inst_ok       = inst_ok_q;
    inst_rdata    = inst_rdata_q;
    data_ok       = data_ok_q;
    data_rdata    = data_rdata_q;
    timeout_err   = terr_q;
    stallreq_data = rst && data_req && !data_ok_q;
    stallreq_inst = rst && inst_req && !inst_ok_q && !flush;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. The bench plays both masters and the SRAM;
// a transaction-level model decides grants, SRAM latency and expected responses.
module tb_mem_arbiter;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = 4'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] sram_rdata = 32'd0;
  logic        sram_ok = 1'b0;
  logic        inst_ok, data_ok, sram_en, stallreq_inst, stallreq_data, timeout_err;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_wen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_ok       (inst_ok),
    .inst_rdata    (inst_rdata),
    .data_req      (data_req),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_ok       (data_ok),
    .data_rdata    (data_rdata),
    .sram_en       (sram_en),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .sram_ok       (sram_ok),
    .stallreq_inst (stallreq_inst),
    .stallreq_data (stallreq_data),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one transaction owns the SRAM port; the cycle after it ends is a
  // turnaround that carries the ok pulse, after which arbitration happens again.
  bit          m_busy, m_is_data, m_turn, m_turn_data, m_turn_inst, m_cancel, m_terr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wen;
  int          m_wait, m_delay;

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_turn = 0; m_turn_data = 0; m_turn_inst = 0;
    m_cancel = 0; m_terr = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_wen = 0;
    m_wait = 0; m_delay = 0;
  endtask

  // SRAM latency: mostly short, sometimes exactly at the limit, sometimes never
  task automatic grant(input bit is_data, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] wd);
    int r;
    m_busy = 1; m_is_data = is_data; m_addr = a; m_wen = w; m_wdata = wd;
    m_wait = 0; m_cancel = 0;
    r = $urandom_range(0, 9);
    if (r < 6) m_delay = r % 4;
    else if (r < 8) m_delay = Timeout;
    else m_delay = 1000;
  endtask

  task automatic model_advance();
    bit timed;
    if (!rst) begin
      model_reset();
    end else if (m_turn) begin
      m_turn = 0; m_turn_data = 0; m_turn_inst = 0; m_cancel = 0;
    end else if (m_busy) begin
      if (!m_is_data && flush) m_cancel = 1;
      if (sram_ok || (m_wait == Timeout)) begin
        timed  = !sram_ok;
        m_busy = 0;
        m_turn = 1;
        if (timed) m_terr = 1;
        if (m_is_data) begin
          m_turn_data = 1;
          m_rdata = (timed || (m_wen != 4'd0)) ? 32'd0 : sram_rdata;
        end else begin
          m_turn_inst = !m_cancel;
          m_rdata = timed ? 32'd0 : sram_rdata;
        end
      end else begin
        m_wait++;
      end
    end else if (data_req) begin
      grant(1, data_addr, data_wen, data_wdata);
    end else if (inst_req && !flush) begin
      grant(0, inst_addr, 4'd0, 32'd0);
    end
  endtask

  task automatic check_outputs();
    bit exp_dok, exp_iok;
    exp_dok = m_turn && m_turn_data;
    exp_iok = m_turn && m_turn_inst;
    check("sram_en", 32'(sram_en), 32'(m_busy));
    check("sram_wen", 32'(sram_wen), m_busy ? 32'(m_wen) : 32'd0);
    if (m_busy) begin
      check("sram_addr", sram_addr, m_addr);
      check("sram_wdata", sram_wdata, m_wdata);
    end
    check("data_ok", 32'(data_ok), 32'(exp_dok));
    check("inst_ok", 32'(inst_ok), 32'(exp_iok));
    if (exp_dok) check("data_rdata", data_rdata, m_rdata);
    if (exp_iok) check("inst_rdata", inst_rdata, m_rdata);
    check("stallreq_data", 32'(stallreq_data), 32'(rst && data_req && !exp_dok));
    check("stallreq_inst", 32'(stallreq_inst), 32'(rst && inst_req && !exp_iok && !flush));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // Masters hold a request until the model says it completed, then maybe issue another
  task automatic drive_masters(input bit d_done, input bit i_done);
    if (!data_req || d_done) begin
      data_req = ($urandom_range(0, 2) != 0);
      if (data_req) begin
        data_addr  = $urandom & 32'hFFFF_FFFC;
        data_wen   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        data_wdata = $urandom;
      end
    end
    if (!inst_req || i_done) begin
      inst_req  = ($urandom_range(0, 1) == 0);
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end else if (flush) begin
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    flush = ($urandom_range(0, 9) == 0);
  endtask

  task automatic step();
    bit d_done, i_done;
    sram_ok    = m_busy && (m_wait == m_delay);
    sram_rdata = $urandom;
    #1;
    check_outputs();
    d_done = m_turn && m_turn_data;
    i_done = m_turn && m_turn_inst;
    @(posedge clk);
    model_advance();
    @(negedge clk);
    drive_masters(d_done, i_done);
  endtask

  initial begin
    bit found;
    model_reset();
    #2 rst = 1'b0;
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) step();

    // Reset in the middle of a data transaction, with the request still held
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_busy && m_is_data && data_req) found = 1;
      else step();
    end
    check("reach_data_for_reset", 32'(found), 32'd1);
    sram_ok = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < 2000; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
